// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32-style control FSM: sequences fetch, decode, execute,
// memory and write-back, raises the datapath strobes for each phase and
// counts retired instructions. SYSTEM or unknown opcodes park it in HALT.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [4:0]       opcode,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_write,
  output logic [2:0]       imm_sel,
  output logic             alu_src_b,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_BAD    = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_SYS, C_ILL
  } cls_t;

  // decoded instruction held from DECODE through WB
  typedef struct packed {
    cls_t       cls;
    logic [2:0] imm;
  } dec_t;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_U = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_B = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_REL = 2'd1;
  localparam logic [1:0] PC_ALU = 2'd2;

  function automatic dec_t decode(input logic [4:0] op);
    dec_t d;
    d.cls = C_ILL;
    d.imm = IMM_I;
    case (op)
      5'b01100: d.cls = C_R;
      5'b00100: d.cls = C_I;
      5'b00000: d.cls = C_LOAD;
      5'b01000: begin d.cls = C_STORE;  d.imm = IMM_S; end
      5'b11000: begin d.cls = C_BRANCH; d.imm = IMM_B; end
      5'b11011: begin d.cls = C_JAL;    d.imm = IMM_J; end
      5'b11001: d.cls = C_JALR;
      5'b01101: begin d.cls = C_LUI;    d.imm = IMM_U; end
      5'b00101: begin d.cls = C_AUIPC;  d.imm = IMM_U; end
      5'b11100: d.cls = C_SYS;
      default:  d.cls = C_ILL;
    endcase
    return d;
  endfunction

  state_t           st_q, st_d;
  dec_t             dec_q, dec_in;
  logic             load_dec, set_ill, retire, ill_q;
  logic [CNT_W-1:0] ret_q;
  logic             use_imm;

  assign dec_in  = decode(opcode);
  // only register-register ALU ops and branch compares take rs2 on port B
  assign use_imm = !(dec_q.cls inside {C_R, C_BRANCH});

  assign state   = st_q;
  assign halted  = (st_q == ST_HALT);
  assign illegal = ill_q;
  assign retired = ret_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  // decoded-class latch, written only in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        dec_q <= '0;
    else if (load_dec) dec_q <= dec_in;
  end

  // sticky illegal flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ill_q <= 1'b0;
    else if (set_ill) ill_q <= 1'b1;
  end

  // retired counter, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ret_q <= '0;
    else if (retire) ret_q <= ret_q + CNT_W'(1);
  end

  // next state and per-phase strobes
  always_comb begin
    st_d      = st_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    imm_sel   = IMM_I;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    pc_write  = 1'b0;
    pc_src    = PC_SEQ;
    load_dec  = 1'b0;
    set_ill   = 1'b0;
    retire    = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (run) st_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          st_d     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        load_dec = 1'b1;
        if (dec_in.cls == C_SYS || dec_in.cls == C_ILL) begin
          set_ill = (dec_in.cls == C_ILL);
          st_d    = ST_HALT;
        end else begin
          st_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        imm_sel   = dec_q.imm;
        alu_src_b = use_imm;
        case (dec_q.cls)
          C_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? PC_REL : PC_SEQ;
            retire   = 1'b1;
            st_d     = run ? ST_FETCH : ST_IDLE;
          end
          C_LOAD, C_STORE: st_d = ST_MEM;
          default:         st_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        imm_sel   = dec_q.imm;
        alu_src_b = use_imm;
        dmem_req  = 1'b1;
        dmem_we   = (dec_q.cls == C_STORE);
        if (dmem_ack) begin
          if (dec_q.cls == C_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            st_d     = run ? ST_FETCH : ST_IDLE;
          end else begin
            st_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        imm_sel   = dec_q.imm;
        alu_src_b = use_imm;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        case (dec_q.cls)
          C_LOAD:  wb_sel = WB_MEM;
          C_JAL:   begin wb_sel = WB_PC4; pc_src = PC_REL; end
          C_JALR:  begin wb_sel = WB_PC4; pc_src = PC_ALU; end
          C_LUI:   wb_sel = WB_IMM;
          default: wb_sel = WB_ALU;
        endcase
        st_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: st_d = ST_HALT;
      default: st_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction aggregate model (latency, strobe
// counts, select values) checked against two instances (32- and 4-bit counter).
module tb_multicycle_ctrl;

  logic clk = 1'b0, rst_n = 1'b1, run = 1'b0, branch_taken = 1'b0;
  logic imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [4:0] opcode = 5'd0;

  logic imem_req, dmem_req, dmem_we, ir_write, alu_src_b, reg_write, pc_write, halted, illegal;
  logic [2:0] imm_sel, state;
  logic [1:0] wb_sel, pc_src;
  logic [31:0] retired;

  logic imem_req4, dmem_req4, dmem_we4, ir_write4, alu_src_b4, reg_write4, pc_write4, halted4, illegal4;
  logic [2:0] imm_sel4, state4;
  logic [1:0] wb_sel4, pc_src4;
  logic [3:0] retired4;

  logic [13:0] sv, sv4;
  assign sv  = {imem_req, dmem_req, dmem_we, ir_write, alu_src_b, reg_write, pc_write,
                imm_sel, wb_sel, pc_src};
  assign sv4 = {imem_req4, dmem_req4, dmem_we4, ir_write4, alu_src_b4, reg_write4, pc_write4,
                imm_sel4, wb_sel4, pc_src4};

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_write(ir_write), .imm_sel(imm_sel), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
    .state(state), .halted(halted), .illegal(illegal), .retired(retired)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .branch_taken(branch_taken),
    .imem_req(imem_req4), .imem_ack(imem_ack), .dmem_req(dmem_req4), .dmem_we(dmem_we4),
    .dmem_ack(dmem_ack), .ir_write(ir_write4), .imm_sel(imm_sel4), .alu_src_b(alu_src_b4),
    .reg_write(reg_write4), .wb_sel(wb_sel4), .pc_write(pc_write4), .pc_src(pc_src4),
    .state(state4), .halted(halted4), .illegal(illegal4), .retired(retired4)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LD = 5'b00000,
                         OP_ST = 5'b01000, OP_BR = 5'b11000, OP_JAL = 5'b11011,
                         OP_JALR = 5'b11001, OP_LUI = 5'b01101, OP_AUI = 5'b00101,
                         OP_SYS = 5'b11100, OP_BAD = 5'b11111;

  typedef struct {
    logic [4:0]  op;
    int          iw, dw;
    logic        bt, rf;
    int          lat, imm, wb, pcs, endst;
    logic [31:0] trace;
  } vec_t;

  typedef struct {
    int   lat, ireq, dreq, dwe, rw, wb, pw, pcs, imm, asb, ret, endst;
    logic ill;
  } exp_t;

  int checks = 0, failures = 0;
  int unsigned exp_ret = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected per-instruction totals from the phase rules: fetch waits iw
  // cycles, data access waits dw cycles, zero-wait latencies 4/5/4/3.
  function automatic exp_t model(input logic [4:0] op, input int iw, input int dw,
                                 input logic bt, input logic rf);
    exp_t e;
    logic hlt = 1'b0, uses_rs2 = 1'b0;
    e.ireq = iw + 1; e.dreq = 0; e.dwe = 0; e.rw = 1; e.wb = 0; e.pw = 1;
    e.pcs = 0; e.imm = 0; e.ret = 1; e.ill = 1'b0; e.lat = 4 + iw;
    case (op)
      OP_R:    uses_rs2 = 1'b1;
      OP_I:    ;
      OP_LD:   begin e.lat = 5 + iw + dw; e.dreq = dw + 1; e.wb = 1; end
      OP_ST:   begin e.lat = 4 + iw + dw; e.dreq = dw + 1; e.dwe = dw + 1;
                     e.rw = 0; e.wb = -1; e.imm = 1; end
      OP_BR:   begin e.lat = 3 + iw; e.rw = 0; e.wb = -1; e.imm = 4;
                     e.pcs = bt ? 1 : 0; uses_rs2 = 1'b1; end
      OP_JAL:  begin e.wb = 2; e.pcs = 1; e.imm = 3; end
      OP_JALR: begin e.wb = 2; e.pcs = 2; end
      OP_LUI:  begin e.wb = 3; e.imm = 2; end
      OP_AUI:  e.imm = 2;
      default: begin hlt = 1'b1; e.ill = (op != OP_SYS); end
    endcase
    if (hlt) begin
      e.lat = 2 + iw; e.rw = 0; e.wb = -1; e.pw = 0; e.pcs = -1; e.imm = -1;
      e.ret = 0; e.asb = 0; e.endst = 6;
    end else begin
      e.asb   = uses_rs2 ? 0 : e.lat - 2 - iw;
      e.endst = rf ? 1 : 0;
    end
    return e;
  endfunction

  // Runs one instruction starting in FETCH; returns at posedge+1 once the
  // controller has left the instruction (next FETCH, IDLE or HALT).
  task automatic run_instr(input logic [4:0] op, input int iw, input int dw, input logic bt,
                           input logic rf, input exp_t e, input logic [31:0] xtr);
    int cyc = 0, ic = 0, dc = 0;
    int n_ireq = 0, n_irw = 0, n_dreq = 0, n_dwe = 0, n_rw = 0, n_pw = 0, n_asb = 0;
    int wb = -1, pcs = -1, imm = -1;
    logic both = 1'b0, drop = 1'b0, pend_i = 1'b0, pend_d = 1'b0, done = 1'b0;
    logic [2:0] last_st;
    logic [31:0] tr = 32'd0;
    while (!done && cyc < 80) begin
      imem_ack     = imem_req && (ic >= iw);
      dmem_ack     = dmem_req && (dc >= dw);
      opcode       = (cyc == iw + 1) ? op : 5'($urandom);
      branch_taken = (cyc == iw + 2) ? bt : 1'($urandom);
      run          = (cyc == e.lat - 1) ? rf : 1'($urandom);
      @(negedge clk);
      last_st = state;
      tr = {tr[27:0], 1'b0, state};
      if ((pend_i && !imem_req) || (pend_d && !dmem_req)) drop = 1'b1;
      pend_i = imem_req && !imem_ack;
      pend_d = dmem_req && !dmem_ack;
      if (imem_req && dmem_req) both = 1'b1;
      if (imem_req) begin n_ireq++; if (!imem_ack) ic++; end
      if (dmem_req) begin n_dreq++; if (dmem_we) n_dwe++; if (!dmem_ack) dc++; end
      if (ir_write)  n_irw++;
      if (reg_write) begin n_rw++; wb = int'(wb_sel); end
      if (pc_write)  begin n_pw++; pcs = int'(pc_src); end
      if (alu_src_b) n_asb++;
      if (state == 3'd3 && imm < 0) imm = int'(imm_sel);
      @(posedge clk); #1;
      cyc++;
      if (state != last_st && (state == 3'd1 || state == 3'd0 || state == 3'd6)) done = 1'b1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    exp_ret += e.ret;
    chk("done", done, 1);
    chk("latency", cyc, e.lat);
    chk("imem_req_cycles", n_ireq, e.ireq);
    chk("ir_write_cycles", n_irw, 1);
    chk("dmem_req_cycles", n_dreq, e.dreq);
    chk("dmem_we_cycles", n_dwe, e.dwe);
    chk("reg_write_cycles", n_rw, e.rw);
    chk("wb_sel", wb, e.wb);
    chk("pc_write_cycles", n_pw, e.pw);
    chk("pc_src", pcs, e.pcs);
    chk("imm_sel", imm, e.imm);
    chk("alu_src_b_cycles", n_asb, e.asb);
    chk("req_overlap", both, 0);
    chk("req_dropped", drop, 0);
    chk("retired", retired, exp_ret);
    chk("retired4", retired4, exp_ret & 32'hF);
    chk("end_state", state, e.endst);
    chk("end_state4", state4, e.endst);
    chk("halted", halted, (e.endst == 6));
    chk("illegal", illegal, e.ill);
    if (xtr != 32'd0) chk("state_trace", tr, xtr);
  endtask

  task automatic do_reset();
    run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    rst_n = 1'b1; #1; rst_n = 1'b0; #1;
    chk("rst_state", state, 0);
    chk("rst_strobes", sv, 0);
    chk("rst_strobes4", sv4, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_retired", retired, 0);
    chk("rst_retired4", retired4, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ret = 0;
  endtask

  task automatic to_fetch();
    run = 1'b0;
    @(negedge clk);
    chk("idle_state", state, 0);
    chk("idle_strobes", sv, 0);
    chk("idle_strobes4", sv4, 0);
    @(posedge clk); #1;
    chk("idle_hold", state, 0);
    run = 1'b1;
    @(posedge clk); #1;
    chk("idle_to_fetch", state, 1);
  endtask

  initial begin
    vec_t tab[12];
    logic [4:0] legal[9];
    exp_t e;
    legal = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUI};
    //         op       iw dw bt    rf    lat imm wb  pcs end trace
    tab[0]  = '{OP_R,    0, 0, 1'b0, 1'b1, 4,  0,  0,  0,  1, 32'h1235};
    tab[1]  = '{OP_LD,   0, 3, 1'b0, 1'b1, 8,  0,  1,  0,  1, 32'h12344445};
    tab[2]  = '{OP_BR,   0, 0, 1'b1, 1'b1, 3,  4, -1,  1,  1, 32'h123};
    tab[3]  = '{OP_BR,   1, 0, 1'b0, 1'b1, 4,  4, -1,  0,  1, 32'h0};
    tab[4]  = '{OP_ST,   0, 0, 1'b0, 1'b0, 4,  1, -1,  0,  0, 32'h1234};
    tab[5]  = '{OP_JAL,  2, 0, 1'b0, 1'b1, 6,  3,  2,  1,  1, 32'h0};
    tab[6]  = '{OP_JALR, 0, 0, 1'b0, 1'b1, 4,  0,  2,  2,  1, 32'h0};
    tab[7]  = '{OP_LUI,  0, 0, 1'b0, 1'b0, 4,  2,  3,  0,  0, 32'h0};
    tab[8]  = '{OP_AUI,  1, 0, 1'b0, 1'b1, 5,  2,  0,  0,  1, 32'h0};
    tab[9]  = '{OP_I,    0, 0, 1'b0, 1'b1, 4,  0,  0,  0,  1, 32'h0};
    tab[10] = '{OP_BR,   0, 0, 1'b1, 1'b0, 3,  4, -1,  1,  0, 32'h0};
    tab[11] = '{OP_ST,   0, 2, 1'b0, 1'b1, 6,  1, -1,  0,  1, 32'h123444};

    do_reset();
    to_fetch();
    for (int i = 0; i < 12; i++) begin
      e = model(tab[i].op, tab[i].iw, tab[i].dw, tab[i].bt, tab[i].rf);
      e.lat = tab[i].lat; e.imm = tab[i].imm; e.wb = tab[i].wb;
      e.pcs = tab[i].pcs; e.endst = tab[i].endst;
      run_instr(tab[i].op, tab[i].iw, tab[i].dw, tab[i].bt, tab[i].rf, e, tab[i].trace);
      if (state == 3'd0) to_fetch();
    end

    // randomized legal instruction stream
    for (int k = 0; k < 300; k++) begin
      logic [4:0] op;
      int iw, dw;
      logic bt, rf;
      op = legal[$urandom_range(0, 8)];
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      bt = 1'($urandom);
      rf = ($urandom_range(0, 3) != 0);
      e  = model(op, iw, dw, bt, rf);
      run_instr(op, iw, dw, bt, rf, e, 32'h0);
      if (state == 3'd0) to_fetch();
    end

    // 4-bit counter wraps after 16 retirements
    do_reset();
    to_fetch();
    for (int k = 0; k < 16; k++) begin
      e = model(OP_R, 0, 0, 1'b0, 1'b1);
      run_instr(OP_R, 0, 0, 1'b0, 1'b1, e, 32'h0);
    end
    chk("wrap_retired4", retired4, 0);
    chk("wrap_retired", retired, 16);

    // reset pulse while a load is waiting in MEM
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0; opcode = OP_LD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    chk("mem_state", state, 4);
    chk("mem_dmem_req", dmem_req, 1);
    rst_n = 1'b0; #1;
    chk("async_dmem_req", dmem_req, 0);
    chk("async_state", state, 0);
    chk("async_retired", retired, 0);
    chk("async_retired4", retired4, 0);
    exp_ret = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    to_fetch();
    e = model(OP_I, 1, 0, 1'b0, 1'b1);
    run_instr(OP_I, 1, 0, 1'b0, 1'b1, e, 32'h0);

    // illegal opcode parks in HALT; run and acks have no effect
    e = model(OP_BAD, 0, 0, 1'b0, 1'b1);
    run_instr(OP_BAD, 0, 0, 1'b0, 1'b1, e, 32'h0);
    for (int k = 0; k < 10; k++) begin
      run = 1'($urandom); imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
      opcode = 5'($urandom);
      @(negedge clk);
      chk("halt_state", state, 6);
      chk("halt_halted", halted, 1);
      chk("halt_illegal", illegal, 1);
      chk("halt_illegal4", illegal4, 1);
      chk("halt_halted4", halted4, 1);
      chk("halt_strobes", sv, 0);
      @(posedge clk); #1;
    end
    do_reset();

    // SYSTEM halts without flagging illegal
    to_fetch();
    e = model(OP_SYS, 2, 0, 1'b0, 1'b1);
    run_instr(OP_SYS, 2, 0, 1'b0, 1'b1, e, 32'h0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
